// File: rtl/spi_write_master.sv
// spi_write_master: turns one 8-bit address / 8-bit data register write per
// req/rdy handshake into a 16-bit frame on a 3-wire link (cs, sclk, sdata).
// The address goes first, then the data, each MSB first.
//
// Ports
//   clk_i    system clock; all state changes on the rising edge
//   rst_i    synchronous, active-high reset
//   req_i    write request; qualifies addr_i / data_i
//   addr_i   register address, captured on acceptance
//   data_i   write data, captured on acceptance
//   rdy_o    block idle; a write is accepted on an edge that sees req_i && rdy_o
//   done_o   one-cycle pulse when a frame completes
//   cs_o     slave select, active-high
//   sclk_o   serial clock, idle low, half-period Div clk_i cycles
//   sdata_o  serial data; only changes while sclk_o is low
//
// Div is the sclk half-period in clk_i cycles and must be at least 1.
// Frame: LEAD, then 16 HIGH phases with 15 LOW phases between them, then
// TRAIL, then GAP. Each phase lasts Div cycles, so cs_o is high for 33*Div
// cycles. Outputs are registered on the same edge that enters a phase.
module spi_write_master #(
  parameter int unsigned Div = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] data_i,
  output logic       rdy_o,
  output logic       done_o,
  output logic       cs_o,
  output logic       sclk_o,
  output logic       sdata_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StHigh,
    StLow,
    StTrail,
    StGap
  } state_e;

  state_e          state_q;
  logic [15:0]     shift_q;
  logic [3:0]      bit_cnt_q;
  logic [CntW-1:0] div_cnt_q;
  logic            rdy_q;
  logic            done_q;
  logic            cs_q;
  logic            sclk_q;
  logic            sdata_q;

  logic phase_end;
  assign phase_end = (div_cnt_q == CntMax);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      rdy_q     <= 1'b0;
      done_q    <= 1'b0;
      cs_q      <= 1'b0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // The divide counter free-runs through every phase of a frame and wraps
      // at the end of each phase, so it is already zero when a phase starts.
      if (state_q != StIdle) begin
        div_cnt_q <= phase_end ? '0 : div_cnt_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          // rdy_q is 0 straight out of reset, so the release edge itself
          // cannot accept; it only raises rdy.
          rdy_q <= 1'b1;
          if (req_i && rdy_q) begin
            shift_q   <= {addr_i, data_i};
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            rdy_q     <= 1'b0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            sdata_q   <= addr_i[7];
            state_q   <= StLead;
          end
        end

        StLead: begin
          if (phase_end) begin
            sclk_q  <= 1'b1;
            state_q <= StHigh;
          end
        end

        StHigh: begin
          if (phase_end) begin
            sclk_q <= 1'b0;
            if (bit_cnt_q == 4'd15) begin
              // After 15 shifts bit 0 of the word sits in the top bit; keep
              // driving it through TRAIL so the slave's last bit stays stable.
              sdata_q <= shift_q[15];
              state_q <= StTrail;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              shift_q   <= {shift_q[14:0], 1'b0};
              sdata_q   <= shift_q[14];
              state_q   <= StLow;
            end
          end
        end

        StLow: begin
          if (phase_end) begin
            sclk_q  <= 1'b1;
            state_q <= StHigh;
          end
        end

        StTrail: begin
          if (phase_end) begin
            cs_q    <= 1'b0;
            sdata_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StGap;
          end
        end

        StGap: begin
          // Raising rdy on the last GAP edge lets the next write be accepted
          // on the very next edge.
          if (phase_end) begin
            rdy_q   <= 1'b1;
            state_q <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rdy_o   = rdy_q;
  assign done_o  = done_q;
  assign cs_o    = cs_q;
  assign sclk_o  = sclk_q;
  assign sdata_o = sdata_q;

endmodule

// File: tb/tb_spi_write_master.sv
// Testbench for spi_write_master. Three instances run with sclk half-periods
// of 2, 4 and 1. A small slave model per instance counts sclk rises while cs
// is high and records each 16-bit word. Every frame is checked cycle by cycle
// against a waveform computed from the frame timing (phase = offset / Div).
module tb_spi_write_master;

  localparam int unsigned DivA = 2;
  localparam int unsigned DivB = 4;
  localparam int unsigned DivC = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [3];
  logic       req   [3];
  logic [7:0] addr  [3];
  logic [7:0] data  [3];
  logic       rdy   [3];
  logic       done  [3];
  logic       cs    [3];
  logic       sclk  [3];
  logic       sdata [3];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  spi_write_master #(.Div(DivA)) u_dut_a (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .addr_i(addr[0]), .data_i(data[0]),
    .rdy_o(rdy[0]), .done_o(done[0]), .cs_o(cs[0]), .sclk_o(sclk[0]), .sdata_o(sdata[0])
  );
  spi_write_master #(.Div(DivB)) u_dut_b (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .addr_i(addr[1]), .data_i(data[1]),
    .rdy_o(rdy[1]), .done_o(done[1]), .cs_o(cs[1]), .sclk_o(sclk[1]), .sdata_o(sdata[1])
  );
  spi_write_master #(.Div(DivC)) u_dut_c (
    .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .addr_i(addr[2]), .data_i(data[2]),
    .rdy_o(rdy[2]), .done_o(done[2]), .cs_o(cs[2]), .sclk_o(sclk[2]), .sdata_o(sdata[2])
  );

  // Slave model: counter held clear while cs is low, one bit per sclk rise,
  // a write is recorded at the 16th rise.
  logic        sl_prev  [3] = '{1'b0, 1'b0, 1'b0};
  logic [14:0] sl_sr    [3];
  int          sl_cnt   [3] = '{0, 0, 0};
  int          rx_cnt   [3] = '{0, 0, 0};
  logic [15:0] rx_words [3][16];

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      sl_prev[g] <= sclk[g];
      if (cs[g] !== 1'b1) begin
        sl_cnt[g] <= 0;
      end else if (sclk[g] === 1'b1 && sl_prev[g] === 1'b0) begin
        sl_sr[g] <= {sl_sr[g][13:0], sdata[g]};
        if (sl_cnt[g] == 15) begin
          rx_words[g][rx_cnt[g] % 16] <= {sl_sr[g], sdata[g]};
          rx_cnt[g] <= rx_cnt[g] + 1;
          sl_cnt[g] <= 0;
        end else begin
          sl_cnt[g] <= sl_cnt[g] + 1;
        end
      end
    end
  end

  function automatic int div_of(input int u);
    case (u)
      0:       return DivA;
      1:       return DivB;
      default: return DivC;
    endcase
  endfunction

  // Expected {cs, sclk, sdata, done, rdy} t cycles after the accept edge.
  // Phase 0 lead, odd phases 1..31 sclk high, even phases 2..30 low,
  // 32 trail, 33 gap; rdy comes back 34 phases in.
  function automatic logic [4:0] exp_out(input int d, input logic [15:0] w, input int t);
    int   ph;
    int   bi;
    logic e_cs, e_sclk, e_sd, e_done, e_rdy;
    ph     = t / d;
    bi     = (ph / 2 > 15) ? 0 : 15 - ph / 2;
    e_cs   = (t < 33 * d);
    e_sclk = (ph <= 31) && (ph % 2 == 1);
    e_sd   = (ph <= 32) ? w[bi] : 1'b0;
    e_done = (t == 33 * d);
    e_rdy  = (t == 34 * d);
    return {e_cs, e_sclk, e_sd, e_done, e_rdy};
  endfunction

  // Requests {a,d} on instance u, waits for acceptance and checks the whole
  // frame. At the first cycle after acceptance req/addr/data become
  // nreq/na/nd; at poke_t req is raised with pa/pd for poke_len cycles.
  task automatic check_frame(input int u, input logic [7:0] a, input logic [7:0] d,
                             input logic nreq, input logic [7:0] na, input logic [7:0] nd,
                             input int poke_t, input int poke_len,
                             input logic [7:0] pa, input logic [7:0] pd, input string name,
                             output int waited, output int acc_cyc);
    int          dv;
    int          rx0;
    int          cs_hi;
    int          rises;
    logic        prev_s;
    logic [15:0] w;
    logic [4:0]  obs;
    logic [4:0]  ex;
    dv = div_of(u);
    w = {a, d};
    rx0 = rx_cnt[u];
    req[u] = 1'b1;
    addr[u] = a;
    data[u] = d;
    waited = 0;
    acc_cyc = 0;
    while (!(rdy[u] === 1'b1) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (waited >= 200) begin
      miscompares++;
      $display("FAIL %s accept: rdy=%b after 200 cycles, required 1", name, rdy[u]);
      req[u] = 1'b0;
      return;
    end
    acc_cyc = cyc + 1;
    cs_hi = 0;
    rises = 0;
    prev_s = 1'b0;
    for (int t = 0; t <= 34 * dv; t++) begin
      @(negedge clk);
      obs = {cs[u], sclk[u], sdata[u], done[u], rdy[u]};
      ex = exp_out(dv, w, t);
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("FAIL %s wave t=%0d: cs/sclk/sdata/done/rdy=%b, required %b", name, t, obs, ex);
      end
      if (cs[u] === 1'b1) cs_hi++;
      if (sclk[u] === 1'b1 && !prev_s) rises++;
      prev_s = (sclk[u] === 1'b1);
      if (t == 0) begin
        req[u] = nreq;
        addr[u] = na;
        data[u] = nd;
      end
      if (t == poke_t) begin
        req[u] = 1'b1;
        addr[u] = pa;
        data[u] = pd;
      end
      if (t == poke_t + poke_len) req[u] = 1'b0;
    end
    vectors++;
    if (cs_hi != 33 * dv) begin
      miscompares++;
      $display("FAIL %s cs_width: %0d cycles, required %0d", name, cs_hi, 33 * dv);
    end
    vectors++;
    if (rises != 16) begin
      miscompares++;
      $display("FAIL %s sclk_rises: %0d, required 16", name, rises);
    end
    vectors++;
    if (rx_cnt[u] != rx0 + 1) begin
      miscompares++;
      $display("FAIL %s slave_writes: %0d, required %0d", name, rx_cnt[u] - rx0, 1);
    end else begin
      vectors++;
      if (rx_words[u][rx0 % 16] !== w) begin
        miscompares++;
        $display("FAIL %s slave_word: %h, required %h", name, rx_words[u][rx0 % 16], w);
      end
    end
  endtask

  task automatic idle_gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    int         waited;
    int         acc;
    logic [7:0] a;
    logic [7:0] d;
    logic [4:0] obs;
    a = 8'($urandom);
    d = 8'($urandom);
    rst[0] = 1'b1;
    req[0] = 1'b1;
    addr[0] = a;
    data[0] = d;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {cs[0], sclk[0], sdata[0], done[0], rdy[0]};
      vectors++;
      if (obs !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_values cycle %0d: cs/sclk/sdata/done/rdy=%b, required 00000", i, obs);
      end
    end
    rst[0] = 1'b0;
    @(negedge clk);
    obs = {cs[0], sclk[0], sdata[0], done[0], rdy[0]};
    vectors++;
    if (obs !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_release: cs/sclk/sdata/done/rdy=%b, required 00001", obs);
    end
    check_frame(0, a, d, 1'b0, 8'($urandom), 8'($urandom), -1, 0, 8'h0, 8'h0,
                "reset_then_frame", waited, acc);
    vectors++;
    if (waited != 0) begin
      miscompares++;
      $display("FAIL reset_first_accept: waited %0d cycles, required 0", waited);
    end
  endtask

  task automatic test_single_frame();
    int waited;
    int acc;
    check_frame(0, 8'hA5, 8'h3C, 1'b0, 8'($urandom), 8'($urandom), -1, 0, 8'h0, 8'h0,
                "single_frame", waited, acc);
    idle_gap(3);
  endtask

  task automatic test_loopback();
    logic [7:0] la [5];
    logic [7:0] ld [5];
    int         waited;
    int         acc;
    la = '{8'h00, 8'hFF, 8'h81, 8'($urandom), 8'($urandom)};
    ld = '{8'hFF, 8'h00, 8'h7E, 8'($urandom), 8'($urandom)};
    for (int i = 0; i < 5; i++) begin
      check_frame(1, la[i], ld[i], 1'b0, 8'($urandom), 8'($urandom), -1, 0, 8'h0, 8'h0,
                  "loopback", waited, acc);
      idle_gap($urandom_range(0, 4));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ba [5];
    logic [7:0] bd [5];
    int         waited;
    int         acc;
    int         prev_acc;
    for (int i = 0; i < 5; i++) begin
      ba[i] = 8'($urandom);
      bd[i] = {6'($urandom), 2'(i)};
    end
    prev_acc = 0;
    for (int f = 0; f < 4; f++) begin
      check_frame(2, ba[f], bd[f], (f < 3), ba[f + 1], bd[f + 1], -1, 0, 8'h0, 8'h0,
                  "back_to_back", waited, acc);
      if (f > 0) begin
        vectors++;
        if (acc - prev_acc != 34 * DivC + 1 || waited != 0) begin
          miscompares++;
          $display("FAIL back_to_back spacing: %0d cycles (waited %0d), required %0d",
                   acc - prev_acc, waited, 34 * DivC + 1);
        end
      end
      prev_acc = acc;
    end
    idle_gap(2);
  endtask

  task automatic test_ignore_busy();
    int         waited;
    int         acc;
    logic [7:0] pa;
    logic [7:0] pd;
    // Short poke mid-frame: no effect on the frame, and never accepted.
    check_frame(0, 8'($urandom), 8'($urandom), 1'b0, 8'h0, 8'h0, 10, 2,
                8'($urandom), 8'($urandom), "busy_short_poke", waited, acc);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (cs[0] !== 1'b0 || rdy[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_no_accept cycle %0d: cs=%b rdy=%b, required cs=0 rdy=1",
                 i, cs[0], rdy[0]);
      end
    end
    // Poke that stays high past the frame end: accepted as soon as rdy returns.
    pa = 8'($urandom);
    pd = 8'($urandom);
    check_frame(0, 8'($urandom), 8'($urandom), 1'b0, 8'h0, 8'h0, 20, 1000, pa, pd,
                "busy_long_poke", waited, acc);
    check_frame(0, pa, pd, 1'b0, 8'($urandom), 8'($urandom), -1, 0, 8'h0, 8'h0,
                "busy_held_req", waited, acc);
    vectors++;
    if (waited != 0) begin
      miscompares++;
      $display("FAIL busy_held_accept: waited %0d cycles, required 0", waited);
    end
    idle_gap(2);
  endtask

  task automatic test_midframe_reset();
    int         rx0;
    int         budget;
    int         rises;
    int         waited;
    int         acc;
    logic       prev_s;
    logic [4:0] obs;
    rx0 = rx_cnt[0];
    req[0] = 1'b1;
    addr[0] = 8'($urandom);
    data[0] = 8'($urandom);
    budget = 0;
    while (rdy[0] !== 1'b1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    req[0] = 1'b0;
    rises = 0;
    prev_s = 1'b0;
    budget = 0;
    while (rises < 7 && budget < 40 * DivA) begin
      if (sclk[0] === 1'b1 && !prev_s) rises++;
      prev_s = (sclk[0] === 1'b1);
      if (rises < 7) @(negedge clk);
      budget++;
    end
    vectors++;
    if (rises != 7) begin
      miscompares++;
      $display("FAIL midreset_rises: saw %0d sclk rises, required 7", rises);
    end
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    obs = {cs[0], sclk[0], sdata[0], done[0], rdy[0]};
    vectors++;
    if (obs !== 5'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: cs/sclk/sdata/done/rdy=%b, required 00000", obs);
    end
    @(negedge clk);
    obs = {cs[0], sclk[0], sdata[0], done[0], rdy[0]};
    vectors++;
    if (obs !== 5'b00001) begin
      miscompares++;
      $display("FAIL midreset_release: cs/sclk/sdata/done/rdy=%b, required 00001", obs);
    end
    idle_gap(3);
    vectors++;
    if (rx_cnt[0] != rx0) begin
      miscompares++;
      $display("FAIL midreset_no_write: %0d slave writes, required 0", rx_cnt[0] - rx0);
    end
    check_frame(0, 8'($urandom), 8'($urandom), 1'b0, 8'h0, 8'h0, -1, 0, 8'h0, 8'h0,
                "midreset_next_frame", waited, acc);
  endtask

  task automatic test_random();
    int waited;
    int acc;
    int u;
    for (int i = 0; i < 6; i++) begin
      u = $urandom_range(0, 2);
      check_frame(u, 8'($urandom), 8'($urandom), 1'b0, 8'($urandom), 8'($urandom),
                  -1, 0, 8'h0, 8'h0, "random", waited, acc);
      idle_gap($urandom_range(0, 3));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      req[i] = 1'b0;
      addr[i] = 8'h0;
      data[i] = 8'h0;
    end
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    rst[2] = 1'b0;
    test_reset();
    test_single_frame();
    test_loopback();
    test_back_to_back();
    test_ignore_busy();
    test_midframe_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
